displejs: RTL and testbench

// Character-LCD driver (HD44780-compatible, 4-bit bus, write-only) for the binary-number game.

---
 rtl/displejs_if.sv | 23 ++
 rtl/displejs.sv | 278 +++++++++++++++++++++++++++
 tb/tb_displejs.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/displejs_if.sv
// LCD-side bundle of the displejs driver: message select from the game FSM
// plus the HD44780 4-bit bus pins and the StrataFlash enable.
interface displejs_if;
  logic [1:0] game_state;
  logic       sf_e;
  logic       e;
  logic       rs;
  logic       rw;
  logic       d;
  logic       c;
  logic       b;
  logic       a;

  modport master (
    output game_state,
    input  sf_e, e, rs, rw, d, c, b, a
  );

  modport slave (
    input  game_state,
    output sf_e, e, rs, rw, d, c, b, a
  );
endinterface

// File: rtl/displejs.sv
// HD44780 4-bit write-only driver: power-up init, then a 16-char line-1 message
// selected by game_state, rewritten whenever game_state differs from what is shown.
module displejs #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int E_PULSE_CYC = 12
) (
  input  logic        clk,
  input  logic        rst,
  displejs_if.slave   lcd
);

  // Cycles for a delay of t_ns nanoseconds, rounded up, never below one.
  function automatic longint cyc_of(input longint t_ns);
    longint c;
    c = (t_ns * longint'(CLK_FREQ_HZ) + 64'sd999_999_999) / 64'sd1_000_000_000;
    return (c < 64'sd1) ? 64'sd1 : c;
  endfunction

  localparam longint T_POWERUP = cyc_of(64'sd15_000_000);
  localparam longint T_4100US  = cyc_of(64'sd4_100_000);
  localparam longint T_CLEAR   = cyc_of(64'sd1_640_000);
  localparam longint T_100US   = cyc_of(64'sd100_000);
  localparam longint T_40US    = cyc_of(64'sd40_000);
  localparam longint T_1US     = cyc_of(64'sd1_000);

  localparam int CW    = $clog2(T_POWERUP + 64'sd1);
  localparam int PW    = $clog2(E_PULSE_CYC + 1);
  localparam int CNT_W = (CW > PW) ? CW : PW;

  localparam logic [CNT_W-1:0] W_POWERUP = CNT_W'(T_POWERUP);
  localparam logic [CNT_W-1:0] W_4100US  = CNT_W'(T_4100US);
  localparam logic [CNT_W-1:0] W_CLEAR   = CNT_W'(T_CLEAR);
  localparam logic [CNT_W-1:0] W_100US   = CNT_W'(T_100US);
  localparam logic [CNT_W-1:0] W_40US    = CNT_W'(T_40US);
  localparam logic [CNT_W-1:0] W_1US     = CNT_W'(T_1US);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [127:0] MSG_START   = "PRESS START     ";
  localparam logic [127:0] MSG_GUESS   = "GUESS NUMBER    ";
  localparam logic [127:0] MSG_CORRECT = "CORRECT!        ";
  localparam logic [127:0] MSG_WRONG   = "WRONG!          ";

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_CONFIG, ST_ADDR, ST_WRITE, ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    X_IDLE, X_SETUP, X_PULSE, X_HOLD, X_WAIT
  } xfer_t;

  // Character idx (0 = leftmost) of message sel.
  function automatic logic [7:0] msg_char(input logic [1:0] sel, input logic [3:0] idx);
    logic [127:0] s;
    int           lsb;
    case (sel)
      2'd0:    s = MSG_START;
      2'd1:    s = MSG_GUESS;
      2'd2:    s = MSG_CORRECT;
      default: s = MSG_WRONG;
    endcase
    lsb = 8 * (15 - int'(idx));
    return s[lsb +: 8];
  endfunction

  state_t           state_r, state_s;
  logic [4:0]       step_r, step_s;
  logic [1:0]       msg_sel_r, msg_sel_s;
  xfer_t            xfer_r, xfer_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             e_r, e_s;
  logic             rs_r, rs_s;
  logic [3:0]       nib_r, nib_s;

  logic             start_s;
  logic             done_s;
  logic [3:0]       job_nib_s;
  logic             job_rs_s;
  logic [CNT_W-1:0] job_wait_s;
  logic             job_skip_s;
  logic             job_last_s;
  logic             is_byte_s;
  logic [7:0]       byte_s;
  logic [3:0]       raw_nib_s;
  logic [CNT_W-1:0] raw_wait_s;

  // Job table: what the transfer engine sends for the current state/step.
  // Bytes take two steps, high nibble on even steps.
  always_comb begin
    job_rs_s   = 1'b0;
    job_skip_s = 1'b0;
    job_last_s = 1'b0;
    is_byte_s  = 1'b0;
    byte_s     = 8'h00;
    raw_nib_s  = 4'h0;
    raw_wait_s = W_40US;
    case (state_r)
      ST_POWERUP: begin
        job_skip_s = 1'b1;
        raw_wait_s = W_POWERUP;
        job_last_s = 1'b1;
      end
      ST_INIT: begin
        job_last_s = (step_r == 5'd3);
        case (step_r[1:0])
          2'd0:    begin raw_nib_s = 4'h3; raw_wait_s = W_4100US; end
          2'd1:    begin raw_nib_s = 4'h3; raw_wait_s = W_100US;  end
          2'd2:    begin raw_nib_s = 4'h3; raw_wait_s = W_40US;   end
          default: begin raw_nib_s = 4'h2; raw_wait_s = W_40US;   end
        endcase
      end
      ST_CONFIG: begin
        is_byte_s  = 1'b1;
        job_last_s = (step_r == 5'd7);
        case (step_r[2:1])
          2'd0:    byte_s = 8'h28;
          2'd1:    byte_s = 8'h06;
          2'd2:    byte_s = 8'h0C;
          default: byte_s = 8'h01;
        endcase
      end
      ST_ADDR: begin
        is_byte_s  = 1'b1;
        job_last_s = (step_r == 5'd1);
        byte_s     = 8'h80;
      end
      ST_WRITE: begin
        is_byte_s  = 1'b1;
        job_rs_s   = 1'b1;
        job_last_s = (step_r == 5'd31);
        byte_s     = msg_char(msg_sel_r, step_r[4:1]);
      end
      default: begin
        job_last_s = 1'b0;
      end
    endcase
    if (is_byte_s) begin
      job_nib_s  = step_r[0] ? byte_s[3:0] : byte_s[7:4];
      job_wait_s = step_r[0] ? ((byte_s == 8'h01) ? W_CLEAR : W_40US) : W_1US;
    end else begin
      job_nib_s  = raw_nib_s;
      job_wait_s = raw_wait_s;
    end
  end

  // Sequencer next-state: advances one step per finished transfer.
  always_comb begin
    state_s   = state_r;
    step_s    = step_r;
    msg_sel_s = msg_sel_r;
    start_s   = (xfer_r == X_IDLE) && (state_r != ST_DONE);
    case (state_r)
      ST_DONE: begin
        if (lcd.game_state != msg_sel_r) begin
          state_s   = ST_ADDR;
          step_s    = 5'd0;
          msg_sel_s = lcd.game_state;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        if (done_s && job_last_s) begin
          step_s = 5'd0;
          case (state_r)
            ST_POWERUP: state_s = ST_INIT;
            ST_INIT:    state_s = ST_CONFIG;
            ST_CONFIG:  begin state_s = ST_ADDR; msg_sel_s = lcd.game_state; end
            ST_ADDR:    state_s = ST_WRITE;
            default:    state_s = ST_DONE;
          endcase
        end else if (done_s) begin
          step_s = step_r + 5'd1;
        end else begin
          step_s = step_r;
        end
      end
    endcase
  end

  // Transfer engine: setup, e pulse, one hold cycle, then the post-write delay.
  always_comb begin
    xfer_s = xfer_r;
    cnt_s  = cnt_r;
    e_s    = e_r;
    rs_s   = rs_r;
    nib_s  = nib_r;
    done_s = 1'b0;
    case (xfer_r)
      X_IDLE: begin
        if (start_s && job_skip_s) begin
          xfer_s = X_WAIT;
          cnt_s  = job_wait_s - CNT_ONE;
        end else if (start_s) begin
          xfer_s = X_SETUP;
          cnt_s  = SETUP_LD;
          rs_s   = job_rs_s;
          nib_s  = job_nib_s;
        end else begin
          xfer_s = X_IDLE;
        end
      end
      X_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          xfer_s = X_PULSE;
          cnt_s  = PULSE_LD;
          e_s    = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      X_PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          xfer_s = X_HOLD;
          e_s    = 1'b0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      X_HOLD: begin
        xfer_s = X_WAIT;
        cnt_s  = job_wait_s - CNT_ONE;
        rs_s   = 1'b0;
        nib_s  = 4'h0;
      end
      X_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          xfer_s = X_IDLE;
          done_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        xfer_s = X_IDLE;
        cnt_s  = CNT_ZERO;
        e_s    = 1'b0;
        rs_s   = 1'b0;
        nib_s  = 4'h0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_POWERUP;
      step_r    <= 5'd0;
      msg_sel_r <= 2'd0;
      xfer_r    <= X_IDLE;
      cnt_r     <= CNT_ZERO;
      e_r       <= 1'b0;
      rs_r      <= 1'b0;
      nib_r     <= 4'h0;
    end else begin
      state_r   <= state_s;
      step_r    <= step_s;
      msg_sel_r <= msg_sel_s;
      xfer_r    <= xfer_s;
      cnt_r     <= cnt_s;
      e_r       <= e_s;
      rs_r      <= rs_s;
      nib_r     <= nib_s;
    end
  end

  assign lcd.sf_e = 1'b1;
  assign lcd.rw   = 1'b0;
  assign lcd.e    = e_r;
  assign lcd.rs   = rs_r;
  assign lcd.d    = nib_r[3];
  assign lcd.c    = nib_r[2];
  assign lcd.b    = nib_r[1];
  assign lcd.a    = nib_r[0];

endmodule

// File: tb/tb_displejs.sv
// Directed bench for displejs: captures nibbles on e falling edges and checks
// the init sequence, messages, timing gaps, pulse widths and reset behaviour.
module tb_displejs;

  localparam int CLK_HZ = 1_000_000;
  localparam int EPW    = 12;

  localparam logic [127:0] S_START   = "PRESS START     ";
  localparam logic [127:0] S_GUESS   = "GUESS NUMBER    ";
  localparam logic [127:0] S_CORRECT = "CORRECT!        ";
  localparam logic [127:0] S_WRONG   = "WRONG!          ";

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rel_cyc = 0;
  int   last_fall = 0;
  int   rise_start = 0;
  logic prev_e = 1'b0;

  logic [4:0] q_val[$];
  int         q_rise[$];
  int         q_fall[$];

  displejs_if lcd();

  displejs #(.CLK_FREQ_HZ(CLK_HZ), .E_PULSE_CYC(EPW)) dut (
    .clk(clk),
    .rst(rst),
    .lcd(lcd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ge(input string tag, input int obs, input int lim);
    tests++;
    assert (obs >= lim) else begin
      fails++;
      $error("FAIL %s: observed %0d expected >= %0d", tag, obs, lim);
    end
  endtask

  // Per-cycle pin checks and nibble capture on e falling edges.
  always @(negedge clk) begin
    chk("sf_e", int'(lcd.sf_e), 1);
    chk("rw", int'(lcd.rw), 0);
    if (lcd.e && !prev_e) rise_start = cyc;
    if (!lcd.e && prev_e) begin
      chk("e_width", cyc - rise_start, EPW);
      q_val.push_back({lcd.rs, lcd.d, lcd.c, lcd.b, lcd.a});
      q_rise.push_back(rise_start);
      q_fall.push_back(cyc);
    end
    prev_e = lcd.e;
  end

  task automatic wait_q(input int n, input int budget);
    int k = 0;
    while (q_val.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk_ge("nibble_count", q_val.size(), n);
  endtask

  task automatic check_nib(input string tag, input logic rs_x, input logic [3:0] nib_x, input int gap);
    logic [4:0] v;
    int r, f;
    if (q_val.size() == 0) begin
      chk(tag, -1, int'({rs_x, nib_x}));
    end else begin
      v = q_val.pop_front();
      r = q_rise.pop_front();
      f = q_fall.pop_front();
      chk(tag, int'(v), int'({rs_x, nib_x}));
      if (gap > 0) chk_ge({tag, "_gap"}, r - last_fall, gap);
      last_fall = f;
    end
  endtask

  task automatic check_byte(input string tag, input logic rs_x, input logic [7:0] by, input int gap);
    check_nib({tag, "_hi"}, rs_x, by[7:4], gap);
    check_nib({tag, "_lo"}, rs_x, by[3:0], 1);
  endtask

  task automatic check_str(input string tag, input logic [127:0] s);
    logic [7:0] ch;
    for (int i = 0; i < 16; i++) begin
      ch = s[8*(15-i) +: 8];
      check_byte($sformatf("%s_ch%0d", tag, i), 1'b1, ch, 40);
    end
  endtask

  task automatic check_init();
    if (q_rise.size() > 0) chk_ge("first_rise", q_rise[0] - rel_cyc, 15000);
    else chk_ge("first_rise", -1, 15000);
    check_nib("init0", 1'b0, 4'h3, 0);
    check_nib("init1", 1'b0, 4'h3, 4100);
    check_nib("init2", 1'b0, 4'h3, 100);
    check_nib("init3", 1'b0, 4'h2, 40);
    check_byte("fset", 1'b0, 8'h28, 40);
    check_byte("entry", 1'b0, 8'h06, 40);
    check_byte("dispon", 1'b0, 8'h0C, 40);
    check_byte("clear", 1'b0, 8'h01, 40);
    check_byte("addr", 1'b0, 8'h80, 1640);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_e", int'(lcd.e), 0);
    chk("rst_rs", int'(lcd.rs), 0);
    chk("rst_data", int'({lcd.d, lcd.c, lcd.b, lcd.a}), 0);
    q_val.delete(); q_rise.delete(); q_fall.delete();
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    lcd.game_state = 2'd1;
    @(negedge clk); #1;
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    chk("idle_e", int'(lcd.e), 0);
    chk("idle_rs", int'(lcd.rs), 0);
    chk("idle_data", int'({lcd.d, lcd.c, lcd.b, lcd.a}), 0);

    // Full init plus GUESS NUMBER
    wait_q(4 + 10 + 32, 30000);
    check_init();
    check_str("guess", S_GUESS);

    // Quiet while game_state unchanged
    repeat (3000) @(negedge clk);
    #1;
    chk("quiet_count", q_val.size(), 0);
    chk("quiet_e", int'(lcd.e), 0);

    // 1 -> 2 rewrites without clear or init
    lcd.game_state = 2'd2;
    wait_q(2 + 32, 5000);
    check_byte("addr2", 1'b0, 8'h80, 40);
    check_str("correct", S_CORRECT);
    repeat (200) @(negedge clk);
    #1;
    chk("quiet2_count", q_val.size(), 0);

    // 0 then 3 during 5th char: PRESS START completes, then WRONG!
    lcd.game_state = 2'd0;
    wait_q(2 + 8, 5000);
    lcd.game_state = 2'd3;
    wait_q(2 + 32 + 2 + 32, 8000);
    check_byte("addr0", 1'b0, 8'h80, 40);
    check_str("start", S_START);
    check_byte("addr3", 1'b0, 8'h80, 40);
    check_str("wrong", S_WRONG);

    // Reset in the middle of a write
    lcd.game_state = 2'd1;
    wait_q(2 + 6, 5000);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_e", int'(lcd.e), 0);
    chk("midrst_rs", int'(lcd.rs), 0);
    chk("midrst_data", int'({lcd.d, lcd.c, lcd.b, lcd.a}), 0);
    do_reset();
    wait_q(4 + 10 + 32, 30000);
    check_init();
    check_str("guess2", S_GUESS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
